// File: rtl/bsg_cycle_stamp_pkg.sv
// Shared types for the cycle-stamp service: counter FSM states, the default
// stamp record, and the round-robin index helper.
package bsg_cycle_stamp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } bsg_cycle_ctr_state_e;

    localparam int unsigned bsg_stamp_width_gp    = 16;
    localparam int unsigned bsg_stamp_id_width_gp = 2;

    // Stamp record at the default configuration; the top builds a
    // width-parameterised equivalent with the same field names.
    typedef struct packed {
        logic [bsg_stamp_id_width_gp-1:0] id;
        logic [bsg_stamp_width_gp-1:0]    stamp;
    } bsg_cycle_stamp_s;

    // Index following idx in a ring of n entries.
    function automatic int unsigned bsg_rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bsg_cycle_ctr_core.sv
// Free-running cycle counter register with enable, synchronous clear and a
// combinational wrap pulse on the all-ones to zero increment.
module bsg_cycle_ctr_core #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               clear_i,
    output logic [width_p-1:0] ctr_o,
    output logic               wrap_o
);

    logic [width_p-1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clear_i) begin
            ctr_d = '0;
        end else if (en_i) begin
            ctr_d = ctr_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Clear wins over a coincident wrap, so the sticky flag stays cleared.
    assign wrap_o = en_i & ~clear_i & (&ctr_q);
    assign ctr_o  = ctr_q;

endmodule

// File: rtl/bsg_cycle_stamp_arb.sv
// Timestamp service: start/stop/clear FSM around a shared counter, round-robin
// capture arbitration and a one-entry valid/yumi stamp output register.
module bsg_cycle_stamp_arb
    import bsg_cycle_stamp_pkg::*;
#(
    parameter int unsigned width_p   = 16,
    parameter int unsigned num_req_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         clear_i,
    input  logic [num_req_p-1:0]         req_v_i,
    output logic [num_req_p-1:0]         req_ready_o,
    output logic                         stamp_v_o,
    output logic [width_p-1:0]           stamp_o,
    output logic [$clog2(num_req_p)-1:0] stamp_id_o,
    input  logic                         stamp_yumi_i,
    output logic [width_p-1:0]           ctr_o,
    output logic                         overflow_o,
    output logic                         running_o
);

    localparam int unsigned id_w_lp = $clog2(num_req_p);

    typedef struct packed {
        logic [id_w_lp-1:0] id;
        logic [width_p-1:0] stamp;
    } slot_s;

    bsg_cycle_ctr_state_e state_q, state_d;
    logic                 ovf_q, ovf_d;
    logic                 slot_v_q, slot_v_d;
    slot_s                slot_q, slot_d;
    logic [id_w_lp-1:0]   rr_ptr_q, rr_ptr_d;

    logic                 ctr_en, ctr_wrap;
    logic [width_p-1:0]   ctr;
    logic                 slot_free;
    logic                 grant_v;
    logic [id_w_lp-1:0]   grant_id;
    int unsigned          scan_idx;

    bsg_cycle_ctr_core #(
        .width_p(width_p)
    ) ctr_core (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .en_i     (ctr_en),
        .clear_i  (clear_i),
        .ctr_o    (ctr),
        .wrap_o   (ctr_wrap)
    );

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_i && !stop_i) state_d = RUN;
                RUN:     if (stop_i && !start_i) state_d = HALT;
                HALT:    if (start_i && !stop_i) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign ctr_en    = (state_q == RUN);
    assign running_o = (state_q == RUN);

    always_comb begin
        ovf_d = ovf_q;
        if (clear_i) begin
            ovf_d = 1'b0;
        end else if (ctr_wrap) begin
            ovf_d = 1'b1;
        end
    end

    // Scan starts at rr_ptr_q and wraps; the first active request wins.
    assign slot_free = ~slot_v_q | stamp_yumi_i;

    always_comb begin
        grant_v     = 1'b0;
        grant_id    = '0;
        req_ready_o = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % num_req_p;
            if (!grant_v && slot_free && req_v_i[id_w_lp'(scan_idx)]) begin
                grant_v  = 1'b1;
                grant_id = id_w_lp'(scan_idx);
            end
        end
        if (grant_v) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        slot_v_d = slot_v_q;
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_v) begin
            slot_v_d     = 1'b1;
            slot_d.id    = grant_id;
            slot_d.stamp = ctr;
            rr_ptr_d     = id_w_lp'(bsg_rr_next(32'(grant_id), num_req_p));
        end else if (stamp_yumi_i) begin
            slot_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            ovf_q    <= 1'b0;
            slot_v_q <= 1'b0;
            slot_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            slot_v_q <= slot_v_d;
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign stamp_v_o  = slot_v_q;
    assign stamp_o    = slot_q.stamp;
    assign stamp_id_o = slot_q.id;
    assign ctr_o      = ctr;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bsg_cycle_stamp_arb.sv
// Bench for bsg_cycle_stamp_arb: a cycle-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bsg_cycle_stamp_arb;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, clear = 1'b0, yumi = 1'b0;
    logic [N-1:0] req = '0;

    logic [N-1:0] ready;
    logic         sv;
    logic [15:0]  stamp;
    logic [1:0]   sid;
    logic [15:0]  ctr;
    logic         ovf, running;

    logic [N-1:0] ready4;
    logic         sv4;
    logic [3:0]   stamp4;
    logic [1:0]   sid4;
    logic [3:0]   ctr4;
    logic         ovf4, running4;

    bsg_cycle_stamp_arb #(.width_p(16), .num_req_p(N)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .stop_i(stop), .clear_i(clear),
        .req_v_i(req), .req_ready_o(ready), .stamp_v_o(sv), .stamp_o(stamp), .stamp_id_o(sid),
        .stamp_yumi_i(yumi), .ctr_o(ctr), .overflow_o(ovf), .running_o(running)
    );

    bsg_cycle_stamp_arb #(.width_p(4), .num_req_p(N)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .stop_i(stop), .clear_i(clear),
        .req_v_i(4'b0000), .req_ready_o(ready4), .stamp_v_o(sv4), .stamp_o(stamp4), .stamp_id_o(sid4),
        .stamp_yumi_i(1'b0), .ctr_o(ctr4), .overflow_o(ovf4), .running_o(running4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the counter is tracked as the total number of increments since
    // the last clear; each DUT's view is that total modulo its width.
    bit     m_run   = 1'b0;
    longint m_cnt   = 0;
    bit     m_v     = 1'b0;
    longint m_stamp = 0;
    int     m_id    = 0;
    int     m_next  = 0;
    int     m_g;
    int     c_g;
    logic [N-1:0] c_ready;

    function automatic int exp_grant();
        int i;
        if (m_v && !yumi) return -1;
        for (int k = 0; k < N; k++) begin
            i = (m_next + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0; m_cnt = 0; m_v = 1'b0; m_stamp = 0; m_id = 0; m_next = 0;
        end else begin
            m_g = exp_grant();
            if (m_g >= 0) begin
                m_v = 1'b1; m_stamp = m_cnt; m_id = m_g; m_next = (m_g + 1) % N;
            end else if (yumi) begin
                m_v = 1'b0;
            end
            if (clear) begin
                m_cnt = 0; m_run = 1'b0;
            end else begin
                if (m_run) m_cnt++;
                if (start && !stop) m_run = 1'b1;
                else if (stop && !start) m_run = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        c_g = exp_grant();
        c_ready = '0;
        if (c_g >= 0) c_ready[c_g] = 1'b1;
        check("ready",     64'(ready),    64'(c_ready));
        check("stamp_v",   64'(sv),       64'(m_v));
        check("stamp",     64'(stamp),    64'(m_stamp % 65536));
        check("stamp_id",  64'(sid),      64'(m_id));
        check("ctr",       64'(ctr),      64'(m_cnt % 65536));
        check("overflow",  64'(ovf),      64'(m_cnt >= 65536));
        check("running",   64'(running),  64'(m_run));
        check("ctr4",      64'(ctr4),     64'(m_cnt % 16));
        check("overflow4", 64'(ovf4),     64'(m_cnt >= 16));
        check("running4",  64'(running4), 64'(m_run));
        check("idle4",     64'({ready4, sv4, stamp4, sid4}), 64'(0));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] held_stamp;
    logic [1:0]  held_id;
    logic [15:0] held_ctr;
    logic [3:0]  exp_order [5];

    initial begin
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

        tick(2);
        check("rst_ctr", 64'(ctr), 0);
        check("rst_v", 64'(sv), 0);
        reset_n = 1'b1;

        // Start, run, stop at 10, resume at 11.
        tick(2);
        start = 1'b1; tick(1); start = 1'b0;
        check("start_run", 64'(running), 1);
        check("start_hold", 64'(ctr), 0);
        tick(9);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop_ctr", 64'(ctr), 10);
        tick(3);
        check("stop_hold", 64'(ctr), 10);
        start = 1'b1; tick(1); start = 1'b0;
        check("restart_hold", 64'(ctr), 10);
        tick(1);
        check("restart_inc", 64'(ctr), 11);

        // 4-bit instance wraps after 16 run cycles.
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clear_ctr", 64'(ctr), 0);
        start = 1'b1; tick(1); start = 1'b0;
        tick(15);
        check("pre_wrap", 64'({ovf4, ctr4}), 64'(5'h0F));
        tick(1);
        check("wrap_ctr4", 64'(ctr4), 0);
        check("wrap_ovf4", 64'(ovf4), 1);
        check("wrap_ctr16", 64'(ctr), 16);
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clr_ovf4", 64'(ovf4), 0);
        check("clr_idle", 64'(running), 0);

        // Round-robin with yumi held high.
        start = 1'b1; tick(1); start = 1'b0;
        req = 4'hF; yumi = 1'b1; #1;
        check("rr_0", 64'(ready), 64'(exp_order[0]));
        for (int i = 1; i < 5; i++) begin
            tick(1);
            check("rr_order", 64'(ready), 64'(exp_order[i]));
            check("rr_id", 64'(sid), 64'(i - 1));
        end

        // Back-pressure holds the pending stamp and blocks all grants.
        yumi = 1'b0; #1;
        check("bp_ready", 64'(ready), 0);
        held_stamp = stamp; held_id = sid;
        check("bp_id", 64'(sid), 3);
        tick(3);
        check("bp_ready2", 64'(ready), 0);
        check("bp_stamp", 64'(stamp), 64'(held_stamp));
        check("bp_id2", 64'(sid), 64'(held_id));
        yumi = 1'b1; #1;
        check("bp_release", 64'(ready), 64'(4'b0001));
        tick(1);
        req = '0; tick(1); yumi = 1'b0;

        // Simultaneous controls.
        start = 1'b1; stop = 1'b1; clear = 1'b1; tick(1);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        check("ssc_run", 64'(running), 0);
        check("ssc_ctr", 64'(ctr), 0);
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("halt_ctr", 64'(ctr), 4);
        start = 1'b1; stop = 1'b1; tick(2);
        start = 1'b0; stop = 1'b0;
        check("ss_halt", 64'(running), 0);
        check("ss_ctr", 64'(ctr), 4);

        // Reset mid-run with a stamp pending.
        start = 1'b1; tick(1); start = 1'b0;
        tick(5);
        req = 4'b0100; tick(1);
        check("pend_id", 64'(sid), 2);
        #1 reset_n = 1'b0;
        #1;
        check("arst_v", 64'(sv), 0);
        check("arst_ctr", 64'(ctr), 0);
        check("arst_run", 64'(running), 0);
        reset_n = 1'b1; req = 4'hF;
        #1;
        check("arst_first", 64'(ready), 64'(4'b0001));
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
